// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the IF and MEM pipeline requesters: one access in flight,
// MEM has priority, fetch cancellation, no-response watchdog with drain, saturating stall count.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no access outstanding; issues MEM first, else IF
// S_IF_WAIT | fetch issued, waiting for m_valid (may be cancelled)
// S_MEM_WAIT| data access issued, waiting for m_valid
// S_DRAIN   | after a watchdog abort, swallow one late m_valid or time out
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_valid,
    output logic              pc_stall,
    output logic              mem_stall,
    output logic              timeout_err,
    output logic [15:0]       stall_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IF_WAIT  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_cancel;
    logic               w_cancel_nxt;
    logic [CNT_W-1:0]   r_wdog;
    logic [CNT_W-1:0]   w_wdog_nxt;
    logic               r_wr;
    logic               w_wr_nxt;
    logic               r_timeout_err;
    logic [15:0]        r_stall_cnt;
    logic               w_tc;
    logic               w_abort;
    logic               w_drop;

    // r_wdog counts cycles since issue (or since entering DRAIN)
    assign w_tc = (r_wdog == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cancel_nxt = r_cancel;
        w_wdog_nxt   = r_wdog;
        w_wr_nxt     = r_wr;
        w_abort      = 1'b0;
        w_drop       = 1'b0;
        m_en         = 1'b0;
        m_wr         = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        if_done      = 1'b0;
        if_rdata     = '0;
        mem_done     = 1'b0;
        mem_rdata    = '0;

        case (r_state)
            S_IDLE: begin
                w_wdog_nxt   = '0;
                w_cancel_nxt = 1'b0;
                // rst gating keeps the command strobe low while reset is held
                if (!rst && mem_req) begin
                    m_en        = 1'b1;
                    m_wr        = mem_wr;
                    m_addr      = mem_addr;
                    m_wdata     = mem_wdata;
                    w_wr_nxt    = mem_wr;
                    w_wdog_nxt  = CNT_W'(1);
                    w_state_nxt = S_MEM_WAIT;
                end else if (!rst && if_req && !if_cancel) begin
                    m_en        = 1'b1;
                    m_addr      = if_addr;
                    w_wr_nxt    = 1'b0;
                    w_wdog_nxt  = CNT_W'(1);
                    w_state_nxt = S_IF_WAIT;
                end
            end

            S_MEM_WAIT: begin
                w_wdog_nxt = r_wdog + 1'b1;
                if (m_valid) begin
                    mem_done    = 1'b1;
                    mem_rdata   = r_wr ? '0 : m_rdata;
                    w_state_nxt = S_IDLE;
                end else if (w_tc) begin
                    mem_done    = 1'b1;
                    w_abort     = 1'b1;
                    w_wdog_nxt  = '0;
                    w_state_nxt = S_DRAIN;
                end
            end

            S_IF_WAIT: begin
                w_wdog_nxt = r_wdog + 1'b1;
                w_drop     = r_cancel | if_cancel;
                if (if_cancel) begin
                    w_cancel_nxt = 1'b1;
                end
                if (m_valid) begin
                    if_done      = ~w_drop;
                    if_rdata     = w_drop ? '0 : m_rdata;
                    w_cancel_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (w_tc) begin
                    if_done      = ~w_drop;
                    w_abort      = 1'b1;
                    w_cancel_nxt = 1'b0;
                    w_wdog_nxt   = '0;
                    w_state_nxt  = S_DRAIN;
                end
            end

            S_DRAIN: begin
                w_wdog_nxt = r_wdog + 1'b1;
                if (m_valid || w_tc) begin
                    w_wdog_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cancel      <= 1'b0;
            r_wdog        <= '0;
            r_wr          <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cancel      <= w_cancel_nxt;
            r_wdog        <= w_wdog_nxt;
            r_wr          <= w_wr_nxt;
            r_timeout_err <= r_timeout_err | w_abort;
            if ((pc_stall || mem_stall) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign pc_stall    = if_req & ~if_done;
    assign mem_stall   = mem_req & ~mem_done;
    assign timeout_err = r_timeout_err;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized requesters and memory,
// all outputs compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_cancel, mem_req, mem_wr, m_valid;
    logic [15:0] if_addr, mem_addr, mem_wdata, m_rdata;
    logic        if_done, mem_done, m_en, m_wr, pc_stall, mem_stall, timeout_err;
    logic [15:0] if_rdata, mem_rdata, m_addr, m_wdata, stall_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_valid(m_valid),
        .pc_stall(pc_stall), .mem_stall(mem_stall),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: one outstanding access described by owner and age
    bit          md_busy, md_own_mem, md_write, md_cancel, md_drain, md_err;
    int          md_age, md_dage;
    logic [15:0] md_cnt;
    bit          last_if_done, last_mem_done, last_issue;
    int          cyc, issue_cyc;

    task automatic model_reset();
        md_busy = 0; md_own_mem = 0; md_write = 0; md_cancel = 0;
        md_drain = 0; md_err = 0; md_age = 0; md_dage = 0; md_cnt = 16'd0;
        last_if_done = 0; last_mem_done = 0; last_issue = 0;
    endtask

    task automatic run_cycle();
        bit iss_mem, iss_if, resp, tout, dropped;
        bit e_if_done, e_mem_done, e_pc, e_ms;
        logic [15:0] e_addr, e_wdata, e_if_rd, e_mem_rd;
        #1;
        iss_mem = !md_busy && !md_drain && mem_req;
        iss_if  = !md_busy && !md_drain && !mem_req && if_req && !if_cancel;
        e_addr  = iss_mem ? mem_addr : (iss_if ? if_addr : 16'h0000);
        e_wdata = iss_mem ? mem_wdata : 16'h0000;
        resp    = md_busy && m_valid;
        tout    = md_busy && !m_valid && (md_age == TO - 1);
        dropped = md_cancel || if_cancel;
        e_mem_done = md_busy && md_own_mem && (resp || tout);
        e_mem_rd   = (md_busy && md_own_mem && resp && !md_write) ? m_rdata : 16'h0000;
        e_if_done  = md_busy && !md_own_mem && (resp || tout) && !dropped;
        e_if_rd    = (e_if_done && resp) ? m_rdata : 16'h0000;
        e_pc = if_req && !e_if_done;
        e_ms = mem_req && !e_mem_done;

        chk("m_en", m_en, iss_mem || iss_if);
        chk("m_wr", m_wr, iss_mem && mem_wr);
        chk("m_addr", m_addr, e_addr);
        chk("m_wdata", m_wdata, e_wdata);
        chk("if_done", if_done, e_if_done);
        chk("if_rdata", if_rdata, e_if_rd);
        chk("mem_done", mem_done, e_mem_done);
        chk("mem_rdata", mem_rdata, e_mem_rd);
        chk("pc_stall", pc_stall, e_pc);
        chk("mem_stall", mem_stall, e_ms);
        chk("timeout_err", timeout_err, md_err);
        chk("stall_cnt", stall_cnt, md_cnt);

        if ((e_pc || e_ms) && md_cnt != 16'hFFFF) md_cnt = md_cnt + 16'd1;
        if (tout) md_err = 1;
        if (md_drain) begin
            if (m_valid || md_dage == TO - 1) md_drain = 0;
            else md_dage++;
        end else if (md_busy) begin
            if (resp || tout) begin
                md_busy = 0;
                md_cancel = 0;
                if (tout) begin
                    md_drain = 1;
                    md_dage = 0;
                end
            end else begin
                md_age++;
                if (!md_own_mem && if_cancel) md_cancel = 1;
            end
        end else if (iss_mem || iss_if) begin
            md_busy = 1; md_own_mem = iss_mem; md_write = iss_mem && mem_wr;
            md_age = 1; md_cancel = 0;
        end
        last_if_done  = e_if_done;
        last_mem_done = e_mem_done;
        last_issue    = iss_mem || iss_if;
        if (last_issue) issue_cyc = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    bit sched_on;
    int sched_cyc;

    initial begin
        rst = 1; if_req = 0; if_cancel = 0; if_addr = 0; mem_req = 0; mem_wr = 0;
        mem_addr = 0; mem_wdata = 0; m_valid = 0; m_rdata = 0; cyc = 0; issue_cyc = 0;
        sched_on = 0; sched_cyc = 0;
        model_reset();

        // reset values, with requests present to show gating
        repeat (2) @(posedge clk);
        #1;
        if_req = 1; mem_req = 1; mem_addr = 16'h1111; m_valid = 1; m_rdata = 16'hDEAD;
        #1;
        chk("rst_m_en", m_en, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_mem_done", mem_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_pc_stall", pc_stall, 1);
        chk("rst_mem_stall", mem_stall, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_timeout_err", timeout_err, 0);
        if_req = 0; mem_req = 0; mem_addr = 0; m_valid = 0; m_rdata = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // fetch, latency 3
        if_req = 1; if_addr = 16'h0010;
        #1; chk("t1_m_en", m_en, 1); chk("t1_m_addr", m_addr, 16'h0010);
        run_cycle();
        run_cycle();
        #1; chk("t1_pc_stall_t2", pc_stall, 1);
        run_cycle();
        m_valid = 1; m_rdata = 16'hA5A5;
        #1; chk("t1_if_done", if_done, 1); chk("t1_if_rdata", if_rdata, 16'hA5A5);
        run_cycle();
        if_req = 0; m_valid = 0; m_rdata = 16'hFFFF;
        #1; chk("t1_stall_cnt", stall_cnt, 3);
        run_cycle();

        // simultaneous requests, latency 2: MEM first
        if_req = 1; if_addr = 16'h0040; mem_req = 1; mem_wr = 0; mem_addr = 16'h0200;
        #1; chk("t2_m_addr_mem", m_addr, 16'h0200);
        run_cycle();
        run_cycle();
        m_valid = 1; m_rdata = 16'h1234;
        #1; chk("t2_mem_done", mem_done, 1); chk("t2_mem_rdata", mem_rdata, 16'h1234);
        chk("t2_if_done_quiet", if_done, 0);
        run_cycle();
        mem_req = 0; m_valid = 0;
        #1; chk("t2_if_issue", m_en, 1); chk("t2_m_addr_if", m_addr, 16'h0040);
        run_cycle();
        run_cycle();
        m_valid = 1; m_rdata = 16'h5555;
        #1; chk("t2_if_done", if_done, 1);
        run_cycle();
        if_req = 0; m_valid = 0;
        run_cycle();

        // cancel in flight, response dropped, next fetch issues
        if_req = 1; if_addr = 16'h0020;
        run_cycle();
        if_cancel = 1;
        run_cycle();
        if_cancel = 0; m_valid = 1; m_rdata = 16'h7777;
        #1; chk("t3_dropped", if_done, 0);
        run_cycle();
        m_valid = 0; if_addr = 16'h0030;
        #1; chk("t3_reissue", m_en, 1); chk("t3_m_addr", m_addr, 16'h0030);
        run_cycle();
        m_valid = 1; m_rdata = 16'h3333;
        #1; chk("t3_if_done", if_done, 1);
        run_cycle();
        if_req = 0; m_valid = 0;
        run_cycle();

        // write
        mem_req = 1; mem_wr = 1; mem_addr = 16'h0300; mem_wdata = 16'hBEEF;
        #1; chk("t4_m_wr", m_wr, 1); chk("t4_m_wdata", m_wdata, 16'hBEEF);
        run_cycle();
        #1; chk("t4_m_wdata_off", m_wdata, 0);
        run_cycle();
        m_valid = 1; m_rdata = 16'hFFFF;
        #1; chk("t4_mem_done", mem_done, 1); chk("t4_mem_rdata", mem_rdata, 0);
        run_cycle();
        mem_req = 0; mem_wr = 0; m_valid = 0;
        run_cycle();

        // watchdog: no response, late m_valid swallowed in drain
        mem_req = 1; mem_addr = 16'h0400;
        run_cycle();
        if_req = 1; if_addr = 16'h0044;
        for (int k = 1; k < 7; k++) run_cycle();
        #1; chk("t5_mem_done", mem_done, 1); chk("t5_mem_rdata", mem_rdata, 0);
        run_cycle();
        mem_req = 0;
        #1; chk("t5_err", timeout_err, 1);
        run_cycle();
        run_cycle();
        m_valid = 1; m_rdata = 16'hCAFE;
        #1; chk("t5_late_if", if_done, 0); chk("t5_late_mem", mem_done, 0);
        run_cycle();
        m_valid = 0;
        #1; chk("t5_if_issue", m_en, 1); chk("t5_err_sticky", timeout_err, 1);
        run_cycle();
        run_cycle();
        m_valid = 1; m_rdata = 16'h0F0F;
        run_cycle();
        if_req = 0; m_valid = 0;
        run_cycle();

        // asynchronous reset while in MEM_WAIT
        mem_req = 1; mem_addr = 16'h0500;
        run_cycle();
        #2;
        rst = 1;
        #1;
        chk("t6_m_en", m_en, 0); chk("t6_err", timeout_err, 0); chk("t6_cnt", stall_cnt, 0);
        m_valid = 1; m_rdata = 16'h9999;
        #1;
        chk("t6_no_done", mem_done, 0); chk("t6_rdata", mem_rdata, 0);
        mem_req = 0; m_valid = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        m_valid = 1; m_rdata = 16'h4242;
        #1; chk("t6_stray", mem_done, 0);
        run_cycle();
        m_valid = 0;

        // randomized requesters and memory
        for (int i = 0; i < 4000; i++) begin
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req = 1; if_addr = 16'($urandom);
                end
            end else if (last_if_done) begin
                if ($urandom_range(0, 1) == 0) if_req = 0;
                else if_addr = 16'($urandom);
            end
            if_cancel = ($urandom_range(0, 15) == 0);
            if (!mem_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    mem_req = 1; mem_wr = 1'($urandom); mem_addr = 16'($urandom);
                    mem_wdata = 16'($urandom);
                end
            end else if (last_mem_done) begin
                if ($urandom_range(0, 1) == 0) mem_req = 0;
                else begin
                    mem_wr = 1'($urandom); mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
                end
            end
            m_valid = ($urandom_range(0, 39) == 0);
            if (sched_on && cyc == sched_cyc) begin
                m_valid = 1;
                sched_on = 0;
            end
            m_rdata = 16'($urandom);
            run_cycle();
            if (last_issue) begin
                sched_on = 1;
                if ($urandom_range(0, 9) == 0) sched_cyc = issue_cyc + TO + $urandom_range(0, 10);
                else sched_cyc = issue_cyc + $urandom_range(1, 4);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
